// File: rtl/register_status_file.sv
// register_status_file
//   Architectural register file with per-register rename tags. It sits between the decoder and
//   the reorder buffer's commit port.
//   - At issue it records which ROB tag will produce each destination register.
//   - At commit it writes the retired value. It releases the tag only if no younger producer
//     has claimed the register since.
//   - It supplies operands to the decoder combinationally, with a same-cycle commit bypass.
//   - Rollback drops every pending tag and keeps the committed values.
//
// Ports
//   clk, rst_n                      clock; synchronous active-low reset
//   rollback_in                     flush all pending tags (issue ignored this cycle)
//   dec_issue_in/rd_in/tag_in       issue: tag[rd] <= tag
//   dec_rs1_in/rs2_in               source register indices
//   dec_Vj_out/Vk_out               operand values
//   dec_Qj_out/Qk_out               pending producer tags (NULL_TAG when the value is valid)
//   commit_rf_signal_in/tag_in/
//   commit_data_in/target_in        retire a register-writing instruction
module register_status_file #(
  parameter int unsigned          REG_COUNT       = 32,
  parameter int unsigned          REG_INDEX_WIDTH = 5,
  parameter int unsigned          XLEN            = 32,
  parameter int unsigned          TAG_WIDTH       = 4,
  parameter logic [TAG_WIDTH-1:0] NULL_TAG        = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rollback_in,
  input  logic                       dec_issue_in,
  input  logic [REG_INDEX_WIDTH-1:0] dec_rd_in,
  input  logic [TAG_WIDTH-1:0]       dec_tag_in,
  input  logic [REG_INDEX_WIDTH-1:0] dec_rs1_in,
  input  logic [REG_INDEX_WIDTH-1:0] dec_rs2_in,
  output logic [XLEN-1:0]            dec_Vj_out,
  output logic [XLEN-1:0]            dec_Vk_out,
  output logic [TAG_WIDTH-1:0]       dec_Qj_out,
  output logic [TAG_WIDTH-1:0]       dec_Qk_out,
  input  logic                       commit_rf_signal_in,
  input  logic [TAG_WIDTH-1:0]       commit_tag_in,
  input  logic [XLEN-1:0]            commit_data_in,
  input  logic [REG_INDEX_WIDTH-1:0] commit_target_in
);

  logic [XLEN-1:0]      value_q [REG_COUNT];
  logic [XLEN-1:0]      value_d [REG_COUNT];
  logic [TAG_WIDTH-1:0] tag_q   [REG_COUNT];
  logic [TAG_WIDTH-1:0] tag_d   [REG_COUNT];

  logic commit_wr;
  logic issue_wr;

  // Register 0 is never written or tagged.
  assign commit_wr = commit_rf_signal_in && (commit_target_in != '0);
  assign issue_wr  = dec_issue_in && (dec_rd_in != '0) && !rollback_in;

  // Next-state logic. Issue is applied after commit, so a same-cycle issue to the committed
  // register leaves the new producer's tag in place.
  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    if (commit_wr) begin
      value_d[commit_target_in] = commit_data_in;
      if (tag_q[commit_target_in] == commit_tag_in) begin
        tag_d[commit_target_in] = NULL_TAG;
      end
    end
    if (rollback_in) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        tag_d[i] = NULL_TAG;
      end
    end else if (issue_wr) begin
      tag_d[dec_rd_in] = dec_tag_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= NULL_TAG;
      end
    end else begin
      value_q <= value_d;
      tag_q   <= tag_d;
    end
  end

  // Operand read. It sees pre-issue state. A matching commit in the same cycle is forwarded,
  // so the decoder never waits a cycle for a value that is retiring right now.
  logic [REG_INDEX_WIDTH-1:0] rs_idx [2];
  logic [XLEN-1:0]            rd_val [2];
  logic [TAG_WIDTH-1:0]       rd_tag [2];

  assign rs_idx[0] = dec_rs1_in;
  assign rs_idx[1] = dec_rs2_in;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_val[p] = '0;
      rd_tag[p] = NULL_TAG;
      if (rs_idx[p] != '0) begin
        if (commit_rf_signal_in && (commit_target_in == rs_idx[p]) &&
            (tag_q[rs_idx[p]] == commit_tag_in)) begin
          rd_val[p] = commit_data_in;
          rd_tag[p] = NULL_TAG;
        end else begin
          rd_val[p] = value_q[rs_idx[p]];
          rd_tag[p] = tag_q[rs_idx[p]];
        end
      end
    end
  end

  assign dec_Vj_out = rd_val[0];
  assign dec_Vk_out = rd_val[1];
  assign dec_Qj_out = rd_tag[0];
  assign dec_Qk_out = rd_tag[1];

endmodule

// File: tb/tb_register_status_file.sv
module tb_register_status_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rollback_in;
  logic        dec_issue_in;
  logic [4:0]  dec_rd_in;
  logic [3:0]  dec_tag_in;
  logic [4:0]  dec_rs1_in;
  logic [4:0]  dec_rs2_in;
  logic [31:0] dec_Vj_out;
  logic [31:0] dec_Vk_out;
  logic [3:0]  dec_Qj_out;
  logic [3:0]  dec_Qk_out;
  logic        commit_rf_signal_in;
  logic [3:0]  commit_tag_in;
  logic [31:0] commit_data_in;
  logic [4:0]  commit_target_in;

  register_status_file dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .rollback_in         (rollback_in),
    .dec_issue_in        (dec_issue_in),
    .dec_rd_in           (dec_rd_in),
    .dec_tag_in          (dec_tag_in),
    .dec_rs1_in          (dec_rs1_in),
    .dec_rs2_in          (dec_rs2_in),
    .dec_Vj_out          (dec_Vj_out),
    .dec_Vk_out          (dec_Vk_out),
    .dec_Qj_out          (dec_Qj_out),
    .dec_Qk_out          (dec_Qk_out),
    .commit_rf_signal_in (commit_rf_signal_in),
    .commit_tag_in       (commit_tag_in),
    .commit_data_in      (commit_data_in),
    .commit_target_in    (commit_target_in)
  );

  always #5 clk = ~clk;

  // Architectural view of the register file: what the rules say each register holds.
  int unsigned m_val [32];
  int unsigned m_tag [32];

  int total_checks = 0;
  int pass_checks  = 0;
  bit check_en     = 1'b0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total_checks++;
    if (act == exp) pass_checks++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int unsigned exp_v(input int unsigned rs);
    if (rs == 0) return 0;
    if (commit_rf_signal_in && commit_target_in == rs && m_tag[rs] == commit_tag_in)
      return commit_data_in;
    return m_val[rs];
  endfunction

  function automatic int unsigned exp_q(input int unsigned rs);
    if (rs == 0) return 0;
    if (commit_rf_signal_in && commit_target_in == rs && m_tag[rs] == commit_tag_in)
      return 0;
    return m_tag[rs];
  endfunction

  // Apply one clock edge's worth of architectural effects, using the inputs present at the edge.
  task automatic model_edge();
    if (!rst_n) begin
      foreach (m_val[i]) begin m_val[i] = 0; m_tag[i] = 0; end
      return;
    end
    if (commit_rf_signal_in && commit_target_in != 0) begin
      m_val[commit_target_in] = commit_data_in;
      if (m_tag[commit_target_in] == commit_tag_in) m_tag[commit_target_in] = 0;
    end
    if (rollback_in) foreach (m_tag[i]) m_tag[i] = 0;
    else if (dec_issue_in && dec_rd_in != 0) m_tag[dec_rd_in] = dec_tag_in;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rollback_in = 0; dec_issue_in = 0; dec_rd_in = 0; dec_tag_in = 0;
    commit_rf_signal_in = 0; commit_tag_in = 0; commit_data_in = 0; commit_target_in = 0;
  endtask

  task automatic issue(input int rd, input int tg);
    dec_issue_in = 1; dec_rd_in = 5'(rd); dec_tag_in = 4'(tg);
  endtask

  task automatic commit(input int tgt, input int tg, input int unsigned data);
    commit_rf_signal_in = 1; commit_target_in = 5'(tgt); commit_tag_in = 4'(tg);
    commit_data_in = data;
  endtask

  task automatic read(input int a, input int b);
    dec_rs1_in = 5'(a); dec_rs2_in = 5'(b); #3;
  endtask

  // Every-cycle comparison against the model, midway between driving and the next edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("Vj", dec_Vj_out, exp_v(dec_rs1_in));
      check("Qj", dec_Qj_out, exp_q(dec_rs1_in));
      check("Vk", dec_Vk_out, exp_v(dec_rs2_in));
      check("Qk", dec_Qk_out, exp_q(dec_rs2_in));
    end
  end

  initial begin
    rst_n = 0; idle(); dec_rs1_in = 0; dec_rs2_in = 0;
    step();
    check_en = 1;
    rst_n = 1;
    read(5, 31);
    check("reset_Vj", dec_Vj_out, 0); check("reset_Qj", dec_Qj_out, 0);
    check("reset_Vk", dec_Vk_out, 0); check("reset_Qk", dec_Qk_out, 0);

    // Issue then commit with bypass.
    issue(3, 2); step(); idle();
    read(3, 0); check("issue_Q", dec_Qj_out, 2);
    commit(3, 2, 32'hDEADBEEF); read(3, 0);
    check("bypass_V", dec_Vj_out, 32'hDEADBEEF); check("bypass_Q", dec_Qj_out, 0);
    step(); idle(); read(3, 0);
    check("commit_V", dec_Vj_out, 32'hDEADBEEF); check("commit_Q", dec_Qj_out, 0);

    // Younger producer keeps its tag.
    issue(7, 1); step(); idle();
    issue(7, 4); step(); idle();
    commit(7, 1, 32'h11); step(); idle(); read(7, 0);
    check("young_V", dec_Vj_out, 32'h11); check("young_Q", dec_Qj_out, 4);
    commit(7, 4, 32'h22); step(); idle(); read(7, 0);
    check("release_V", dec_Vj_out, 32'h22); check("release_Q", dec_Qj_out, 0);

    // Same-cycle commit and issue to one register.
    issue(9, 3); step(); idle();
    commit(9, 3, 32'h55); issue(9, 6); read(9, 0);
    check("sc_pre_V", dec_Vj_out, 32'h55); check("sc_pre_Q", dec_Qj_out, 0);
    step(); idle(); read(9, 0);
    check("sc_post_V", dec_Vj_out, 32'h55); check("sc_post_Q", dec_Qj_out, 6);

    // Rollback flushes tags, keeps values, still takes the commit.
    commit(2, 0, 32'h1234); step(); idle();
    issue(1, 5); step(); idle();
    issue(2, 6); step(); idle();
    rollback_in = 1; issue(4, 7); commit(1, 5, 32'h99); read(1, 2);
    check("rb_same_Q2", dec_Qk_out, 6);
    step(); idle(); read(1, 2);
    check("rb_x1_V", dec_Vj_out, 32'h99); check("rb_x1_Q", dec_Qj_out, 0);
    check("rb_x2_V", dec_Vk_out, 32'h1234); check("rb_x2_Q", dec_Qk_out, 0);
    read(4, 0); check("rb_x4_Q", dec_Qj_out, 0);

    // x0 is immutable.
    issue(0, 3); commit(0, 0, 32'hFF); read(0, 0);
    check("x0_V", dec_Vj_out, 0); check("x0_Q", dec_Qj_out, 0);
    step(); idle(); read(0, 0);
    check("x0_post_V", dec_Vj_out, 0); check("x0_post_Q", dec_Qj_out, 0);

    // Reset overrides a same-cycle issue and commit.
    rst_n = 0; issue(5, 3); commit(5, 0, 32'hAA); step(); rst_n = 1; idle();
    read(5, 3);
    check("rst_x5_V", dec_Vj_out, 0); check("rst_x5_Q", dec_Qj_out, 0);
    check("rst_x3_V", dec_Vk_out, 0); check("rst_x3_Q", dec_Qk_out, 0);

    // Random traffic; commit tags usually match the current producer so releases happen.
    for (int n = 0; n < 3000; n++) begin
      int unsigned tgt;
      rst_n        = ($urandom_range(0, 199) != 0);
      rollback_in  = ($urandom_range(0, 19) == 0);
      dec_issue_in = $urandom_range(0, 1);
      dec_rd_in    = 5'($urandom_range(0, 31));
      dec_tag_in   = 4'($urandom_range(0, 15));
      tgt          = $urandom_range(0, 31);
      commit_rf_signal_in = $urandom_range(0, 1);
      commit_target_in    = 5'(tgt);
      commit_tag_in       = ($urandom_range(0, 3) != 0) ? 4'(m_tag[tgt]) : 4'($urandom_range(0, 15));
      commit_data_in      = $urandom;
      // Bias reads toward the registers being touched to exercise bypass and pre-issue views.
      dec_rs1_in = ($urandom_range(0, 1) != 0) ? 5'(tgt) : 5'($urandom_range(0, 31));
      dec_rs2_in = ($urandom_range(0, 2) == 0) ? dec_rd_in : 5'($urandom_range(0, 31));
      step();
    end

    idle(); rst_n = 1;
    step();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
